uart_word_tx: RTL and testbench

//  Parametrised word-to-byte serializer feeding the byte-level UART Transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uwtx_fifo.sv | 51 +++++
 rtl/uart_word_tx.sv | 184 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the word-to-byte UART serializer.
// Optional feature macro used by the top: UWTX_DELIM_EN (delimiter after each word).
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        ACK   = 3'd3,
        WAIT  = 3'd4,
        DELIM = 3'd5
    } uwtx_state_t;

endpackage

// File: rtl/uwtx_fifo.sv
// Synchronous FIFO holding {byte count, word} entries for the serializer.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module uwtx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    // A write is refused while full even if a pop happens the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers; they wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-byte serializer in front of a byte-level UART Transmitter.
// Queues words with per-word byte counts and hands bytes over with a start/busy handshake.
// Define UWTX_DELIM_EN to append DELIM_BYTE after every word that carried at least one byte.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int         WORD_BYTES = 4,
    parameter int         DEPTH      = 4,
    parameter int         MSB_FIRST  = 0,
    parameter logic [7:0] DELIM_BYTE = 8'h0A,
    localparam int        WW         = BYTE_W * WORD_BYTES,
    localparam int        CW         = $clog2(WORD_BYTES + 1),
    localparam int        LW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [WW-1:0] wr_word,
    input  logic [CW-1:0] wr_bytes,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int FW = WW + CW;

    // FIFO plumbing
    logic [CW-1:0] bytes_clamped;
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [WW-1:0] head_word;
    logic [CW-1:0] head_cnt;

    // FSM state and datapath registers
    uwtx_state_t   state,    state_nxt;
    logic [WW-1:0] word_reg, word_nxt;
    logic [CW-1:0] cnt_reg,  cnt_nxt;
    logic          start_r,  start_nxt;
    logic [7:0]    data_r,   data_nxt;
    logic [7:0]    cur_byte;
`ifdef UWTX_DELIM_EN
    logic          delim_phase, delim_nxt;
`endif

    // Oversized counts are clamped before they enter the queue.
    assign bytes_clamped = (wr_bytes > CW'(WORD_BYTES)) ? CW'(WORD_BYTES) : wr_bytes;
    assign wr_ready      = !fifo_full;

    uwtx_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid),
        .din   ({bytes_clamped, wr_word}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign head_word = fifo_dout[WW-1:0];
    assign head_cnt  = fifo_dout[WW +: CW];

    // MSB-first: shift the word left so byte[n-1] lands in the top byte lane.
    // Constant shift per candidate count keeps this a mux, not a barrel shifter.
    function automatic logic [WW-1:0] align_msb(input logic [WW-1:0] w, input logic [CW-1:0] n);
        logic [WW-1:0] r;
        r = w;
        for (int i = 1; i <= WORD_BYTES; i++) begin
            if (n == CW'(i)) r = w << (BYTE_W * (WORD_BYTES - i));
        end
        return r;
    endfunction

    assign cur_byte = (MSB_FIRST != 0) ? word_reg[WW-1 -: BYTE_W] : word_reg[BYTE_W-1:0];

    assign tx_start = start_r;
    assign tx_data  = data_r;
    assign busy     = !fifo_empty || (state != IDLE);

    // Next-state and datapath decode for the byte handshake sequencer.
    always_comb begin
        state_nxt = state;
        word_nxt  = word_reg;
        cnt_nxt   = cnt_reg;
        start_nxt = start_r;
        data_nxt  = data_r;
        fifo_pop  = 1'b0;
`ifdef UWTX_DELIM_EN
        delim_nxt = delim_phase;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD: begin
                fifo_pop  = 1'b1;
                word_nxt  = (MSB_FIRST != 0) ? align_msb(head_word, head_cnt) : head_word;
                cnt_nxt   = head_cnt;
                // Zero-byte entries are simply discarded.
                state_nxt = (head_cnt == '0) ? IDLE : START;
            end
            START: begin
                start_nxt = 1'b1;
                data_nxt  = cur_byte;
                state_nxt = ACK;
            end
            ACK: begin
                if (tx_busy) begin
                    start_nxt = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
`ifdef UWTX_DELIM_EN
                    if (delim_phase) begin
                        delim_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
`else
                    begin
`endif
                        if (cnt_reg != '0) cnt_nxt = cnt_reg - CW'(1);
                        word_nxt = (MSB_FIRST != 0) ? (word_reg << BYTE_W) : (word_reg >> BYTE_W);
                        if (cnt_reg > CW'(1)) begin
                            state_nxt = START;
                        end else begin
`ifdef UWTX_DELIM_EN
                            state_nxt = DELIM;
`else
                            state_nxt = IDLE;
`endif
                        end
                    end
                end
            end
`ifdef UWTX_DELIM_EN
            DELIM: begin
                // Delimiter reuses the ACK/WAIT handshake; the flag routes WAIT back to IDLE.
                start_nxt = 1'b1;
                data_nxt  = DELIM_BYTE;
                delim_nxt = 1'b1;
                state_nxt = ACK;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any word in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_reg    <= '0;
            cnt_reg     <= '0;
            start_r     <= 1'b0;
            data_r      <= '0;
`ifdef UWTX_DELIM_EN
            delim_phase <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            word_reg    <= word_nxt;
            cnt_reg     <= cnt_nxt;
            start_r     <= start_nxt;
            data_r      <= data_nxt;
`ifdef UWTX_DELIM_EN
            delim_phase <= delim_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: one LSB-first and one MSB-first instance,
// each driving a Transmitter model (busy rises 1 cycle after start, holds 10 cycles).
module tb_uart_word_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // LSB-first instance signals
    logic        l_wr_valid, l_wr_ready, l_tx_start, l_busy;
    logic [31:0] l_wr_word;
    logic [2:0]  l_wr_bytes, l_level;
    logic [7:0]  l_tx_data;
    logic        l_tx_busy = 1'b0;
    int          l_bcnt    = 0;
    bit          l_stall   = 1'b0;
    logic [7:0]  l_q[$];

    // MSB-first instance signals
    logic        m_wr_valid, m_wr_ready, m_tx_start, m_busy;
    logic [31:0] m_wr_word;
    logic [2:0]  m_wr_bytes, m_level;
    logic [7:0]  m_tx_data;
    logic        m_tx_busy = 1'b0;
    int          m_bcnt    = 0;
    logic [7:0]  m_q[$];

    uart_word_tx #(.WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(0), .DELIM_BYTE(8'h0A)) u_lsb (
        .clk(clk), .rst(rst), .wr_valid(l_wr_valid), .wr_ready(l_wr_ready),
        .wr_word(l_wr_word), .wr_bytes(l_wr_bytes), .tx_start(l_tx_start),
        .tx_data(l_tx_data), .tx_busy(l_tx_busy), .busy(l_busy), .level(l_level));

    uart_word_tx #(.WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(1), .DELIM_BYTE(8'h0A)) u_msb (
        .clk(clk), .rst(rst), .wr_valid(m_wr_valid), .wr_ready(m_wr_ready),
        .wr_word(m_wr_word), .wr_bytes(m_wr_bytes), .tx_start(m_tx_start),
        .tx_data(m_tx_data), .tx_busy(m_tx_busy), .busy(m_busy), .level(m_level));

    // Transmitter models: latch byte on start, busy for 10 cycles, unaffected by rst.
    always @(posedge clk) begin
        if (l_bcnt != 0) begin
            l_bcnt <= l_bcnt - 1;
            if (l_bcnt == 1) l_tx_busy <= 1'b0;
        end else if (l_tx_start && !l_tx_busy && !l_stall) begin
            l_tx_busy <= 1'b1;
            l_bcnt    <= 10;
            l_q.push_back(l_tx_data);
        end
    end

    always @(posedge clk) begin
        if (m_bcnt != 0) begin
            m_bcnt <= m_bcnt - 1;
            if (m_bcnt == 1) m_tx_busy <= 1'b0;
        end else if (m_tx_start && !m_tx_busy) begin
            m_tx_busy <= 1'b1;
            m_bcnt    <= 10;
            m_q.push_back(m_tx_data);
        end
    end

    // Called at a negedge; word accepted at the following posedge if ready.
    task automatic push_l(input logic [31:0] w, input logic [2:0] b);
        l_wr_valid = 1'b1; l_wr_word = w; l_wr_bytes = b;
        @(negedge clk);
        l_wr_valid = 1'b0;
    endtask

    task automatic push_m(input logic [31:0] w, input logic [2:0] b);
        m_wr_valid = 1'b1; m_wr_word = w; m_wr_bytes = b;
        @(negedge clk);
        m_wr_valid = 1'b0;
    endtask

    task automatic wait_idle_l(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!l_busy && !l_tx_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle_m(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!m_busy && !m_tx_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (l_tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", l_tx_start); end
        checks++; if (l_tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", l_tx_data); end
        checks++; if (l_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", l_level); end
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", l_busy); end
        checks++; if (l_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", l_wr_ready); end
        checks++; if (m_busy !== 1'b0 || m_tx_start !== 1'b0) begin errors++; $display("FAIL rst_msb got busy=%b start=%b want 0/0", m_busy, m_tx_start); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lsb;
        logic [7:0] exp[$];
        bit         done;
        exp = '{8'hD4, 8'hC3, 8'hB2};
        l_q.delete();
        push_l(32'hA1B2C3D4, 3'd3);
        checks++; if (l_tx_start !== 1'b0) begin errors++; $display("FAIL lat_n0 got %b want 0", l_tx_start); end
        @(negedge clk);
        checks++; if (l_tx_start !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b want 0", l_tx_start); end
        @(negedge clk);
        checks++; if (l_tx_start !== 1'b0) begin errors++; $display("FAIL lat_n2 got %b want 0", l_tx_start); end
        @(negedge clk);
        checks++; if (l_tx_start !== 1'b1 || l_tx_data !== 8'hD4) begin errors++; $display("FAIL lat_n3 got start=%b data=%h want 1/d4", l_tx_start, l_tx_data); end
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!l_busy) begin done = 1'b1; break; end
        end
        checks++; if (!done) begin errors++; $display("FAIL lsb_drain got timeout want busy=0"); end
        checks++; if (l_tx_busy !== 1'b0) begin errors++; $display("FAIL lsb_busy_order got tx_busy=%b want 0 when busy falls", l_tx_busy); end
        checks++; if (l_q.size() != exp.size()) begin errors++; $display("FAIL lsb_count got %0d want %0d", l_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= l_q.size() || l_q[i] !== exp[i]) begin
                errors++; $display("FAIL lsb_byte%0d got %h want %h", i, (i < l_q.size()) ? l_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_msb;
        logic [7:0] exp[$];
        bit         ok;
        exp = '{8'hB2, 8'hC3, 8'hD4};
        m_q.delete();
        push_m(32'hA1B2C3D4, 3'd3);
        wait_idle_m(ok);
        checks++; if (!ok) begin errors++; $display("FAIL msb3_drain got timeout want idle"); end
        checks++; if (m_q.size() != exp.size()) begin errors++; $display("FAIL msb3_count got %0d want %0d", m_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= m_q.size() || m_q[i] !== exp[i]) begin
                errors++; $display("FAIL msb3_byte%0d got %h want %h", i, (i < m_q.size()) ? m_q[i] : 8'hxx, exp[i]);
            end
        end
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        m_q.delete();
        push_m(32'hA1B2C3D4, 3'd4);
        wait_idle_m(ok);
        checks++; if (!ok) begin errors++; $display("FAIL msb4_drain got timeout want idle"); end
        checks++; if (m_q.size() != exp.size()) begin errors++; $display("FAIL msb4_count got %0d want %0d", m_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= m_q.size() || m_q[i] !== exp[i]) begin
                errors++; $display("FAIL msb4_byte%0d got %h want %h", i, (i < m_q.size()) ? m_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_fill;
        logic [7:0] exp[$];
        logic [7:0] ws[5];
        logic       rdy_exp[5];
        bit         ok;
        ws      = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        l_q.delete();
        l_stall = 1'b1;
        push_l(32'h11, 3'd1);
        repeat (4) @(negedge clk);
        checks++; if (l_tx_start !== 1'b1 || l_level !== 3'd0) begin errors++; $display("FAIL fill_stalled got start=%b level=%0d want 1/0", l_tx_start, l_level); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (l_wr_ready !== rdy_exp[i]) begin errors++; $display("FAIL fill_ready%0d got %b want %b", i, l_wr_ready, rdy_exp[i]); end
            l_wr_valid = 1'b1; l_wr_word = {24'h0, ws[i]}; l_wr_bytes = 3'd1;
            @(negedge clk);
        end
        l_wr_valid = 1'b0;
        checks++; if (l_level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", l_level); end
        checks++; if (l_wr_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", l_wr_ready); end
        l_stall = 1'b0;
        wait_idle_l(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_drain got timeout want idle"); end
        checks++; if (l_q.size() != exp.size()) begin errors++; $display("FAIL fill_count got %0d want %0d", l_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= l_q.size() || l_q[i] !== exp[i]) begin
                errors++; $display("FAIL fill_byte%0d got %h want %h", i, (i < l_q.size()) ? l_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_zero_clamp;
        logic [7:0] exp[$];
        bit         ok;
        exp = '{8'h04, 8'h03, 8'h02, 8'h01};
        l_q.delete();
        push_l(32'hDEADBEEF, 3'd0);
        push_l(32'h01020304, 3'd7);
        checks++; if (l_level !== 3'd2) begin errors++; $display("FAIL zc_level got %0d want 2", l_level); end
        wait_idle_l(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zc_drain got timeout want idle"); end
        checks++; if (l_q.size() != exp.size()) begin errors++; $display("FAIL zc_count got %0d want %0d", l_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= l_q.size() || l_q[i] !== exp[i]) begin
                errors++; $display("FAIL zc_byte%0d got %h want %h", i, (i < l_q.size()) ? l_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        bit ok;
        l_q.delete();
        push_l(32'hCAFEF00D, 3'd4);
        push_l(32'h0BADBEEF, 3'd4);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (l_q.size() == 1 && l_tx_start && !l_tx_busy) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rm_reach_ack2 got timeout want byte2 ack"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (l_tx_start !== 1'b0) begin errors++; $display("FAIL rm_tx_start got %b want 0", l_tx_start); end
        checks++; if (l_level !== 3'd0) begin errors++; $display("FAIL rm_level got %0d want 0", l_level); end
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", l_busy); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!l_tx_busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL rm_tx_settle got timeout want tx_busy=0"); end
        checks++; if (l_q.size() != 2 || l_q[1] !== 8'hF0) begin errors++; $display("FAIL rm_inflight got n=%0d want 2 bytes ending f0", l_q.size()); end
        checks++; if (l_busy !== 1'b0 || l_tx_start !== 1'b0) begin errors++; $display("FAIL rm_stays_idle got busy=%b start=%b want 0/0", l_busy, l_tx_start); end
        l_q.delete();
        push_l(32'h0000005A, 3'd1);
        wait_idle_l(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_fresh_drain got timeout want idle"); end
        checks++; if (l_q.size() != 1 || l_q[0] !== 8'h5A) begin errors++; $display("FAIL rm_fresh got n=%0d want single 5a", l_q.size()); end
    endtask

    task automatic test_delim;
        logic [7:0] exp[$];
        bit         ok;
`ifdef UWTX_DELIM_EN
        exp = '{8'h34, 8'h12, 8'h0A};
`else
        exp = '{8'h34, 8'h12};
`endif
        l_q.delete();
        push_l(32'h00001234, 3'd2);
        push_l(32'h0000FFFF, 3'd0);
        wait_idle_l(ok);
        checks++; if (!ok) begin errors++; $display("FAIL delim_drain got timeout want idle"); end
        checks++; if (l_q.size() != exp.size()) begin errors++; $display("FAIL delim_count got %0d want %0d", l_q.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= l_q.size() || l_q[i] !== exp[i]) begin
                errors++; $display("FAIL delim_byte%0d got %h want %h", i, (i < l_q.size()) ? l_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        l_wr_valid = 1'b0; l_wr_word = '0; l_wr_bytes = '0;
        m_wr_valid = 1'b0; m_wr_word = '0; m_wr_bytes = '0;
        @(negedge clk);
        test_reset();
        test_lsb();
        test_msb();
        test_fill();
        test_zero_clamp();
        test_reset_mid();
        test_delim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
